rv_axi_mem_slave: RTL and testbench

- AXI4 responder (subordinate) fronting a local single-port block RAM of 32-bit words.
- It is the counterpart of the rv32 core's AXI initiator port. Accel-side test memory and scratchpad hang off it, and so do any CPU-visible buffers.
- Accepts single-beat and INCR bursts on shared AW/W/B/AR/R channels.
- Serializes write and read transactions through one FSM.

---
 rtl/rv_axi_mem_slave.sv | 148 ++++++++++++++
 tb/tb_rv_axi_mem_slave.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_axi_mem_slave.sv
// AXI4 subordinate in front of a single-port word RAM. One FSM serializes
// write and read bursts; single-beat and INCR bursts with 1-cycle read latency.
module rv_axi_mem_slave #(
  parameter logic [15:0] BASE = 16'h0010,
  parameter logic [15:0] LAST = 16'h7FFF,
  parameter int          AW   = 12
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic [39:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  input  logic        wlast,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [39:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rd_data,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic        rlast,
  input  logic        rready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_BRESP = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [7:0]    len, cnt;
  logic          hit;

  logic [31:0]   mem [2**AW];
  logic [31:0]   ram_q;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;

  logic aw_hs, ar_hs, w_hs, r_hs, r_more;

  // wlast and the sub-word/unused address bits carry no information here
  logic unused_ok;
  assign unused_ok = ^{wlast, awaddr, araddr};

  function automatic logic in_window(input logic [39:0] a);
    return (a[39:32] == 8'h00) && (a[31:16] >= BASE) && (a[31:16] <= LAST);
  endfunction

  // Handshakes are refused while reset is held so no beat is taken mid-reset
  assign awready = arst_n && (state == S_IDLE);
  assign arready = arst_n && (state == S_IDLE) && !awvalid;
  assign wready  = (state == S_WDATA);
  assign bvalid  = (state == S_BRESP);
  assign rvalid  = (state == S_RDATA);
  assign rlast   = rvalid && (cnt == len);
  assign bresp   = (bvalid && !hit) ? 2'b11 : 2'b00;
  assign rresp   = (rvalid && !hit) ? 2'b11 : 2'b00;
  assign rd_data = (rvalid && hit) ? ram_q : 32'h0;

  assign aw_hs  = awvalid && awready;
  assign ar_hs  = arvalid && arready;
  assign w_hs   = wvalid && wready;
  assign r_hs   = rvalid && rready;
  assign r_more = r_hs && (cnt != len);

  // idx always points at the word currently being written or presented
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 4'h0;
    ram_addr = idx;
    if (arst_n) begin
      if (ar_hs) begin
        ram_en   = 1'b1;
        ram_addr = araddr[AW+1:2];
      end else if (r_more) begin
        ram_en   = 1'b1;
        ram_addr = idx + 1'b1;
      end else if (w_hs && hit) begin
        ram_we   = wstrb;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= wr_data[8*b +: 8];
    if (ram_en) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      len   <= '0;
      cnt   <= '0;
      hit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            state <= S_WDATA;
            idx   <= awaddr[AW+1:2];
            len   <= awlen;
            cnt   <= '0;
            hit   <= in_window(awaddr);
          end else if (ar_hs) begin
            state <= S_RDATA;
            idx   <= araddr[AW+1:2];
            len   <= arlen;
            cnt   <= '0;
            hit   <= in_window(araddr);
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            idx <= idx + 1'b1;
            cnt <= cnt + 8'd1;
            if (cnt == len) state <= S_BRESP;
          end
        end
        S_BRESP: begin
          if (bready) state <= S_IDLE;
        end
        default: begin
          if (r_hs) begin
            if (cnt == len) begin
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
              cnt <= cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_axi_mem_slave.sv
// Randomized bench for rv_axi_mem_slave (AW=4) against a word-array memory model.
module tb_rv_axi_mem_slave;

  logic        aclk, arst_n;
  logic [39:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  rv_axi_mem_slave #(.BASE(16'h0010), .LAST(16'h7FFF), .AW(4)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wr_data(wr_data), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rd_data(rd_data), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  // memory model and write-beat stimulus
  logic [31:0] ref_mem [16];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  // observed read beats
  logic [31:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  logic        rq_last [$];
  int          rq_cyc [$];

  function automatic bit m_hit(input logic [39:0] a);
    return (a[39:32] == 8'h00) && (a[31:16] >= 16'h0010) && (a[31:16] <= 16'h7FFF);
  endfunction

  function automatic logic [31:0] m_rd(input logic [39:0] a, input int i);
    return m_hit(a) ? ref_mem[(int'(a[5:2]) + i) % 16] : 32'h0;
  endfunction

  task automatic m_write(input logic [39:0] a, input int nb);
    int w;
    if (!m_hit(a)) return;
    for (int i = 0; i < nb; i++) begin
      w = (int'(a[5:2]) + i) % 16;
      for (int b = 0; b < 4; b++)
        if (wstb[i][b]) ref_mem[w][8*b +: 8] = wdat[i][8*b +: 8];
    end
  endtask

  // Drivers start at a falling edge and return at a falling edge.
  task automatic do_write(input logic [39:0] a, input int len, input int stop_beats,
                          input int bhold, input bit gaps, output logic [1:0] br,
                          output int awc, output int bc, output int viol, output bit to);
    bit got;
    int i;
    to = 0; viol = 0; br = 2'b00; awc = 0; bc = 0; got = 0;
    awaddr = a; awlen = 8'(len); awvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1 got = awready;
      @(negedge aclk);
      if (got) break;
    end
    awvalid = 1'b0;
    awc = cyc;
    if (!got) begin to = 1; return; end
    i = 0;
    for (int t = 0; t < 200 && i <= len && i != stop_beats; t++) begin
      wvalid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data = wdat[i]; wstrb = wstb[i]; wlast = (i == len);
      #1 got = wvalid && wready;
      @(negedge aclk);
      if (got) i++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (i == stop_beats) return;
    if (i <= len) begin to = 1; return; end
    bready = 1'b0;
    got = 0;
    for (int t = 0; t < 50; t++) begin
      #1 got = bvalid;
      if (got) break;
      @(negedge aclk);
    end
    if (!got) begin to = 1; return; end
    for (int t = 0; t < bhold; t++) begin
      if (!(bvalid === 1'b1 && awready === 1'b0)) viol++;
      @(negedge aclk);
      #1;
    end
    bready = 1'b1;
    #1 br = bresp; got = bvalid;
    @(negedge aclk);
    bc = cyc; bready = 1'b0;
    if (!got) to = 1;
  endtask

  // mode 0: rready=1, 1: pattern bits then 1, 2: random
  task automatic do_read(input logic [39:0] a, input int len, input int mode,
                         input logic [15:0] pat, input int abort_beat,
                         output int arc, output int viol, output bit to);
    bit got, rr, hold;
    int n, pi;
    logic [31:0] hd; logic [1:0] hr; logic hl;
    rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_cyc.delete();
    to = 0; viol = 0; arc = 0; got = 0; hold = 0; n = 0; pi = 0;
    hd = '0; hr = '0; hl = 0;
    araddr = a; arlen = 8'(len); arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1 got = arready;
      @(negedge aclk);
      if (got) break;
    end
    arvalid = 1'b0;
    arc = cyc;
    if (!got) begin to = 1; return; end
    for (int t = 0; t < 300 && n <= len; t++) begin
      if (mode == 0) rr = 1'b1;
      else if (mode == 1) rr = (pi < 16) ? pat[pi] : 1'b1;
      else rr = 1'($urandom_range(0, 1));
      pi++;
      rready = rr;
      #1;
      if (n == abort_beat) return;
      if (hold && (rvalid !== 1'b1 || rd_data !== hd || rresp !== hr || rlast !== hl)) viol++;
      if (rvalid && rr) begin
        rq_data.push_back(rd_data); rq_resp.push_back(rresp);
        rq_last.push_back(rlast);   rq_cyc.push_back(cyc + 1);
        n++; hold = 0;
      end else if (rvalid) begin
        hold = 1; hd = rd_data; hr = rresp; hl = rlast;
      end
      @(negedge aclk);
    end
    rready = 1'b0;
    if (n <= len) to = 1;
  endtask

  task automatic test_reset();
    logic [1:0] br; int awc, bc, viol; bit to;
    repeat (2) @(negedge aclk);
    #1;
    n_chk++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rd_data} !== 42'h0)
      $display("FAIL reset_outputs got %h want 0",
               {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rd_data});
    else n_pass++;
    arst_n = 1'b1;
    @(negedge aclk);
    #1;
    n_chk++;
    if ({awready, arready} !== 2'b11) $display("FAIL reset_idle_ready got %b want 11", {awready, arready});
    else n_pass++;
    for (int i = 0; i < 16; i++) begin wdat[i] = 32'h0; wstb[i] = 4'hF; ref_mem[i] = 32'h0; end
    do_write(40'h00_0010_0000, 15, -1, 0, 0, br, awc, bc, viol, to);
    n_chk++;
    if (to || br !== 2'b00) $display("FAIL init_zero_burst bresp %b timeout %0d want 00/0", br, to);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [1:0] br; int awc, bc, viol, arc; bit to;
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    do_write(40'h00_0010_0010, 0, -1, 0, 0, br, awc, bc, viol, to);
    m_write(40'h00_0010_0010, 1);
    n_chk++;
    if (to || br !== 2'b00 || bc - awc != 2)
      $display("FAIL single_write bresp %b b_lat %0d to %0d want 00/2/0", br, bc - awc, to);
    else n_pass++;
    do_read(40'h00_0010_0010, 0, 0, 16'h0, -1, arc, viol, to);
    n_chk++;
    if (to || rq_data[0] !== 32'hDEADBEEF || rq_last[0] !== 1'b1 || rq_resp[0] !== 2'b00 || rq_cyc[0] != arc + 1)
      $display("FAIL single_read data %h last %b resp %b lat %0d want deadbeef/1/00/1",
               to ? 32'hx : rq_data[0], to ? 1'bx : rq_last[0], to ? 2'bx : rq_resp[0],
               to ? -1 : rq_cyc[0] - arc);
    else n_pass++;
  endtask

  task automatic test_burst_strobes();
    logic [1:0] br; int awc, bc, viol, arc; bit to;
    logic [31:0] exp [4];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h00003333; exp[3] = 32'h44440000;
    wdat[0] = 32'h11111111; wdat[1] = 32'h22222222; wdat[2] = 32'h33333333; wdat[3] = 32'h44444444;
    wstb[0] = 4'hF; wstb[1] = 4'hF; wstb[2] = 4'h3; wstb[3] = 4'hC;
    do_write(40'h00_0010_0000, 3, -1, 0, 0, br, awc, bc, viol, to);
    m_write(40'h00_0010_0000, 4);
    n_chk++;
    if (to || br !== 2'b00) $display("FAIL burst_write bresp %b to %0d want 00/0", br, to);
    else n_pass++;
    do_read(40'h00_0010_0000, 3, 0, 16'h0, -1, arc, viol, to);
    n_chk++;
    if (to || rq_data.size() != 4) $display("FAIL burst_read_count got %0d want 4", rq_data.size());
    else n_pass++;
    for (int k = 0; k < rq_data.size() && k < 4; k++) begin
      n_chk++;
      if (rq_data[k] !== exp[k] || rq_last[k] !== (k == 3) || rq_cyc[k] != arc + 1 + k)
        $display("FAIL burst_beat%0d data %h last %b cyc %0d want %h/%b/%0d",
                 k, rq_data[k], rq_last[k], rq_cyc[k], exp[k], (k == 3), arc + 1 + k);
      else n_pass++;
    end
    #1;
    n_chk++;
    if (rvalid !== 1'b0 || rlast !== 1'b0) $display("FAIL burst_end rvalid %b rlast %b want 0/0", rvalid, rlast);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [1:0] br; int awc, bc, viol, arc; bit to;
    do_read(40'h00_0010_0000, 3, 1, 16'h0059, -1, arc, viol, to);
    n_chk++;
    if (to || viol != 0 || rq_data.size() != 4)
      $display("FAIL bp_read unstable %0d beats %0d to %0d want 0/4/0", viol, rq_data.size(), to);
    else n_pass++;
    for (int k = 0; k < rq_data.size(); k++) begin
      n_chk++;
      if (rq_data[k] !== m_rd(40'h00_0010_0000, k) || rq_last[k] !== (k == 3))
        $display("FAIL bp_beat%0d data %h last %b want %h/%b", k, rq_data[k], rq_last[k],
                 m_rd(40'h00_0010_0000, k), (k == 3));
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(40'h00_0010_0028, 1, -1, 5, 0, br, awc, bc, viol, to);
    m_write(40'h00_0010_0028, 2);
    n_chk++;
    if (to || viol != 0 || br !== 2'b00)
      $display("FAIL bp_bhold violations %0d bresp %b to %0d want 0/00/0", viol, br, to);
    else n_pass++;
    do_read(40'h00_0010_0028, 1, 0, 16'h0, -1, arc, viol, to);
    n_chk++;
    if (to || rq_data[0] !== m_rd(40'h00_0010_0028, 0) || rq_data[1] !== m_rd(40'h00_0010_0028, 1))
      $display("FAIL bp_readback got %h want %h", to ? 32'hx : rq_data[0], m_rd(40'h00_0010_0028, 0));
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [1:0] br; int awc, bc, viol, arc; bit to;
    wdat[0] = $urandom; wstb[0] = 4'hF;
    awaddr = 40'h00_0010_0020; awlen = 8'd0; awvalid = 1'b1;
    araddr = 40'h00_0010_0020; arlen = 8'd0; arvalid = 1'b1;
    #1;
    n_chk++;
    if ({awready, arready} !== 2'b10) $display("FAIL simul_ready got %b want 10", {awready, arready});
    else n_pass++;
    do_write(40'h00_0010_0020, 0, -1, 2, 0, br, awc, bc, viol, to);
    m_write(40'h00_0010_0020, 1);
    do_read(40'h00_0010_0020, 0, 0, 16'h0, -1, arc, viol, to);
    n_chk++;
    if (to || arc != bc + 1 || rq_data[0] !== wdat[0])
      $display("FAIL simul_order ar_after_b %0d data %h want 1/%h", arc - bc,
               to ? 32'hx : rq_data[0], wdat[0]);
    else n_pass++;
  endtask

  task automatic test_miss();
    logic [1:0] br; int awc, bc, viol, arc; bit to;
    logic [39:0] wa [4];
    logic [1:0]  we [4];
    wa[0] = 40'h00_8000_0000; we[0] = 2'b11;
    wa[1] = 40'h01_0010_0004; we[1] = 2'b11;
    wa[2] = 40'h00_000F_FFFC; we[2] = 2'b11;
    wa[3] = 40'h00_7FFF_FFFC; we[3] = 2'b00;
    for (int j = 0; j < 4; j++) begin
      wdat[0] = (j == 0) ? 32'hFFFFFFFF : $urandom; wstb[0] = 4'hF;
      do_write(wa[j], 0, -1, 0, 0, br, awc, bc, viol, to);
      m_write(wa[j], 1);
      n_chk++;
      if (to || br !== we[j]) $display("FAIL miss_bresp%0d got %b want %b", j, br, we[j]);
      else n_pass++;
    end
    do_read(40'h00_0010_0000, 15, 0, 16'h0, -1, arc, viol, to);
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (to || rq_data[k] !== ref_mem[k])
        $display("FAIL miss_ram_word%0d got %h want %h", k, to ? 32'hx : rq_data[k], ref_mem[k]);
      else n_pass++;
    end
    do_read(40'h00_0000_0100, 1, 2, 16'h0, -1, arc, viol, to);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (to || rq_data[k] !== 32'h0 || rq_resp[k] !== 2'b11 || rq_last[k] !== (k == 1))
        $display("FAIL miss_read_beat%0d data %h resp %b want 0/11", k,
                 to ? 32'hx : rq_data[k], to ? 2'bx : rq_resp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_reset();
    logic [1:0] br; int awc, bc, viol, arc; bit to;
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(40'h00_0010_0038, 3, -1, 0, 0, br, awc, bc, viol, to);
    m_write(40'h00_0010_0038, 4);
    do_read(40'h00_0010_0000, 15, 0, 16'h0, -1, arc, viol, to);
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (to || rq_data[k] !== ref_mem[k])
        $display("FAIL wrap_word%0d got %h want %h", k, to ? 32'hx : rq_data[k], ref_mem[k]);
      else n_pass++;
    end
    do_read(40'h00_0010_0000, 7, 0, 16'h0, 2, arc, viol, to);
    rready = 1'b0; arst_n = 1'b0;
    @(negedge aclk);
    #1;
    n_chk++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rd_data} !== 42'h0)
      $display("FAIL midread_reset got %h want 0",
               {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rd_data});
    else n_pass++;
    arst_n = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(40'h00_0010_0018, 3, 2, 0, 0, br, awc, bc, viol, to);
    arst_n = 1'b0;
    @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);
    m_write(40'h00_0010_0018, 2);
    do_read(40'h00_0010_0018, 3, 0, 16'h0, -1, arc, viol, to);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (to || rq_data[k] !== m_rd(40'h00_0010_0018, k))
        $display("FAIL partial_write_beat%0d got %h want %h", k, to ? 32'hx : rq_data[k],
                 m_rd(40'h00_0010_0018, k));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0] br; int awc, bc, viol, arc, len; bit to;
    logic [39:0] a;
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 5))
        0:       a = {8'h00, 16'h8000 + 16'($urandom_range(0, 255)), 16'($urandom)};
        1:       a = {8'($urandom_range(1, 255)), 16'h0010, 16'($urandom)};
        default: a = {8'h00, 16'h0010 + 16'($urandom_range(0, 2)), 16'($urandom)};
      endcase
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      do_write(a, len, -1, $urandom_range(0, 3), 1, br, awc, bc, viol, to);
      m_write(a, len + 1);
      n_chk++;
      if (to || br !== (m_hit(a) ? 2'b00 : 2'b11))
        $display("FAIL rand%0d_bresp got %b want %b to %0d", it, br, m_hit(a) ? 2'b00 : 2'b11, to);
      else n_pass++;
      a = (it % 3 == 0) ? a : {8'h00, 16'h0010, 16'($urandom)};
      len = $urandom_range(0, 9);
      do_read(a, len, 2, 16'h0, -1, arc, viol, to);
      n_chk++;
      if (to || viol != 0) $display("FAIL rand%0d_read unstable %0d to %0d want 0/0", it, viol, to);
      else n_pass++;
      for (int k = 0; k < rq_data.size(); k++) begin
        n_chk++;
        if (rq_data[k] !== m_rd(a, k) || rq_resp[k] !== (m_hit(a) ? 2'b00 : 2'b11) || rq_last[k] !== (k == len))
          $display("FAIL rand%0d_beat%0d data %h resp %b last %b want %h/%b/%b", it, k,
                   rq_data[k], rq_resp[k], rq_last[k], m_rd(a, k), m_hit(a) ? 2'b00 : 2'b11, (k == len));
        else n_pass++;
      end
    end
  endtask

  initial begin
    arst_n = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wr_data = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_single();
    test_burst_strobes();
    test_backpressure();
    test_simultaneous();
    test_miss();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
